cop_arbiter: RTL and testbench

// - Shares one GCD/LCM Coprocessor between NREQ requesters (core ports / accelerator clients).
// - Round-robin arbitration; drives start/x0/y0/Op; waits for Done; returns the result on a valid/ready response.
// - Times out a hung operation and resets the coprocessor.
// - Sits between requester ports and one Coprocessor instance; the only block that drives it.

---
 rtl/cop_arbiter_if.sv | 26 ++
 rtl/cop_arbiter.sv | 166 ++++++++++++++++
 tb/tb_cop_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cop_arbiter_if.sv
// Requester-side bundle of the coprocessor arbiter: request and response
// handshakes. slave = arbiter side, master = requester side.
interface cop_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_x;
  logic [NREQ*WIDTH-1:0] req_y;
  logic [NREQ-1:0]       req_op;
  logic [NREQ-1:0]       resp_valid;
  logic [NREQ-1:0]       resp_ready;
  logic [WIDTH-1:0]      resp_result;
  logic                  resp_err;

  modport slave (
    input  req_valid, req_x, req_y, req_op, resp_ready,
    output req_ready, resp_valid, resp_result, resp_err
  );

  modport master (
    output req_valid, req_x, req_y, req_op, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_err
  );
endinterface

// File: rtl/cop_arbiter.sv
// Round-robin arbiter sharing one GCD/LCM coprocessor between NREQ ports.
// Ports: clk/reset; bus (requests/responses); cop_* to the coprocessor;
// busy/grant_id status. Hung operations time out and flush the coprocessor.
module cop_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    reset,
  cop_arbiter_if.slave            bus,
  output logic                    cop_start,
  output logic [WIDTH-1:0]        cop_x0,
  output logic [WIDTH-1:0]        cop_y0,
  output logic                    cop_op,
  output logic                    cop_reset,
  input  logic                    cop_done,
  input  logic [WIDTH-1:0]        cop_result,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);
  localparam int IDW = $clog2(NREQ);
  localparam int TW  = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_FLUSH, S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             op_q, op_d;
  logic             err_q, err_d;
  logic             seen_q, seen_d;
  logic [TW-1:0]    tmr_q, tmr_d;

  logic [IDW-1:0]   pick;
  logic [IDW-1:0]   cand;
  logic             found;
  logic             done_ok;
  logic [NREQ-1:0]  ready;
  logic [NREQ-1:0]  rv;
  logic             start;
  logic             flush;

  // First valid port after the last served one.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(rr_q) + k) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    x_d     = x_q;
    y_d     = y_q;
    op_d    = op_q;
    res_d   = res_q;
    err_d   = err_q;
    seen_d  = seen_q;
    tmr_d   = tmr_q;
    ready   = '0;
    rv      = '0;
    start   = 1'b0;
    flush   = 1'b0;
    // Done counts only after it was seen low for this op.
    done_ok = cop_done && seen_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          ready[pick] = 1'b1;
          gnt_d       = pick;
          x_d         = bus.req_x[pick*WIDTH +: WIDTH];
          y_d         = bus.req_y[pick*WIDTH +: WIDTH];
          op_d        = bus.req_op[pick];
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        start   = 1'b1;
        tmr_d   = '0;
        seen_d  = !cop_done;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        seen_d = seen_q | !cop_done;
        if (done_ok) begin
          res_d   = cop_result;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_FLUSH;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_FLUSH: begin
        flush   = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        rv[gnt_q] = 1'b1;
        if (bus.resp_ready[gnt_q]) begin
          rr_d    = gnt_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rr_q    <= IDW'(NREQ - 1);
      gnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      op_q    <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
      seen_q  <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
      tmr_q   <= tmr_d;
    end
  end

  logic rsp;
  assign rsp = (state_q == S_RESP) && !reset;

  assign bus.req_ready   = reset ? '0 : ready;
  assign bus.resp_valid  = reset ? '0 : rv;
  assign bus.resp_result = rsp ? res_q : '0;
  assign bus.resp_err    = rsp & err_q;
  assign cop_start       = start & !reset;
  assign cop_x0          = x_q;
  assign cop_y0          = y_q;
  assign cop_op          = op_q;
  assign cop_reset       = reset | flush;
  assign busy            = state_q != S_IDLE;
  assign grant_id        = gnt_q;
endmodule

// File: tb/tb_cop_arbiter.sv
// Scoreboard bench for cop_arbiter with a behavioural GCD/LCM coprocessor.
// Expected responses are queued at request time and popped on handshake.
module tb_cop_arbiter;
  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cop_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  logic             cop_start, cop_op, cop_reset, cop_done, busy;
  logic [WIDTH-1:0] cop_x0, cop_y0, cop_result;
  logic [1:0]       grant_id;

  cop_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .cop_start(cop_start), .cop_x0(cop_x0), .cop_y0(cop_y0),
    .cop_op(cop_op), .cop_reset(cop_reset), .cop_done(cop_done),
    .cop_result(cop_result), .busy(busy), .grant_id(grant_id)
  );

  function automatic logic [7:0] ref_f(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic op);
    int x, y, t;
    x = int'(a);
    y = int'(b);
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    if (!op) return 8'(x);
    if (x == 0) return 8'd0;
    return 8'((int'(a) / x) * int'(b));
  endfunction

  // mode 0: normal, 1: Done stays low, 2: Done left as is (stale high)
  int         mode = 0;
  int         lat = 2;
  int         cnt = 0;
  logic       done_r;
  logic [7:0] res_r;
  assign cop_done   = done_r;
  assign cop_result = res_r;

  always @(posedge clk) begin
    if (cop_reset) begin
      done_r <= 1'b0;
      cnt    <= 0;
    end else if (cop_start) begin
      res_r <= ref_f(cop_x0, cop_y0, cop_op);
      if (mode != 2) begin
        done_r <= 1'b0;
        cnt    <= (mode == 0) ? lat : 0;
      end
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) done_r <= 1'b1;
    end
  end

  typedef struct {
    int         port;
    logic [7:0] res;
    logic       err;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [3:0] pend = '0;
  logic [3:0] pop = '0;
  logic [3:0] rmask = '1;
  logic [7:0] px[4];
  logic [7:0] py[4];
  int         nops[4];

  logic [3:0] s_rdy, s_rv, prev_rv;
  logic [7:0] s_res, prev_res;
  logic       s_err, s_busy, s_crst, s_start, prev_err;
  logic [1:0] s_gid;
  logic       rv_prev = 1'b0;
  int cyc = 0, acc_cyc = 0, last_lat = 0;
  int start_cnt = 0, flush_cnt = 0, flush_at_resp = 0;

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_x[i*WIDTH +: WIDTH] = px[i];
      bus.req_y[i*WIDTH +: WIDTH] = py[i];
    end
    bus.req_valid  = pend;
    bus.req_op     = pop;
    bus.resp_ready = rmask;
  endtask

  task automatic mon();
    int   idx;
    exp_t e;
    cyc++;
    s_rdy   = bus.req_ready;
    s_rv    = bus.resp_valid;
    s_res   = bus.resp_result;
    s_err   = bus.resp_err;
    s_busy  = busy;
    s_crst  = cop_reset;
    s_start = cop_start;
    s_gid   = grant_id;
    if (reset) begin
      rv_prev = 1'b0;
      return;
    end
    if (cop_start) start_cnt++;
    if (cop_reset) flush_cnt++;
    if (s_rdy != 0) begin
      chk("ready_onehot", 32'($onehot(s_rdy)), 1);
      idx = 0;
      for (int i = 0; i < NREQ; i++) if (s_rdy[i]) idx = i;
      if (sb.size() > 0) chk("accept_port", idx, sb[0].port);
      else chk("unexpected_accept", 1, 0);
      acc_cyc = cyc;
      if (nops[idx] > 0) nops[idx]--;
      if (nops[idx] == 0) pend[idx] = 1'b0;
    end
    if (s_busy && sb.size() > 0) chk("grant_id", 32'(s_gid), sb[0].port);
    if (s_rv != 0) begin
      if (rv_prev) begin
        chk("resp_valid_stable", 32'(s_rv), 32'(prev_rv));
        chk("resp_result_stable", 32'(s_res), 32'(prev_res));
        chk("resp_err_stable", 32'(s_err), 32'(prev_err));
      end else begin
        last_lat      = cyc - acc_cyc;
        flush_at_resp = flush_cnt;
      end
      if ((s_rv & bus.resp_ready) != 0) begin
        chk("resp_onehot", 32'($onehot(s_rv)), 1);
        idx = 0;
        for (int i = 0; i < NREQ; i++) if (s_rv[i]) idx = i;
        if (sb.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("resp_port", idx, e.port);
          chk("resp_result", 32'(s_res), 32'(e.res));
          chk("resp_err", 32'(s_err), 32'(e.err));
        end
        rv_prev = 1'b0;
      end else begin
        rv_prev  = 1'b1;
        prev_rv  = s_rv;
        prev_res = s_res;
        prev_err = s_err;
      end
    end else begin
      rv_prev = 1'b0;
    end
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input int i, input logic [7:0] x,
                      input logic [7:0] y, input logic op, input int n);
    px[i]   = x;
    py[i]   = y;
    pop[i]  = op;
    nops[i] = n;
    pend[i] = 1'b1;
  endtask

  task automatic push(input int port, input logic [7:0] res,
                      input logic err);
    exp_t e;
    e.port = port;
    e.res  = res;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((sb.size() != 0 || busy || pend != 0) && n < maxc) begin
      tick();
      n++;
    end
    if (n >= maxc) chk("wait_idle_budget", 0, 1);
  endtask

  task automatic wait_resp(input int maxc);
    int n = 0;
    s_rv = '0;
    while (s_rv == 0 && n < maxc) begin
      tick();
      n++;
    end
    if (n >= maxc) chk("wait_resp_budget", 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, f0, n;
    for (int i = 0; i < NREQ; i++) begin
      px[i]   = '0;
      py[i]   = '0;
      nops[i] = 0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    tick();
    chk("rst_cop_reset", 32'(s_crst), 1);
    reset = 1'b0;
    tick();
    chk("post_rst_busy", 32'(s_busy), 0);
    chk("post_rst_resp_valid", 32'(s_rv), 0);
    chk("post_rst_req_ready", 32'(s_rdy), 0);
    chk("post_rst_cop_reset", 32'(s_crst), 0);
    chk("post_rst_grant_id", 32'(s_gid), 0);
    chk("post_rst_cop_start", 32'(s_start), 0);

    // single GCD on port 0
    s0 = start_cnt;
    push(0, 8'd6, 1'b0);
    post(0, 8'd48, 8'd18, 1'b0, 1);
    wait_idle(50);
    chk("gcd_start_pulses", start_cnt - s0, 1);
    chk("gcd_latency", last_lat, 5);

    // LCM on port 2
    push(2, 8'd12, 1'b0);
    post(2, 8'd4, 8'd6, 1'b1, 1);
    wait_idle(50);

    // fairness with all ports held valid
    do_reset();
    s0 = start_cnt;
    for (int k = 0; k < 6; k++) begin
      push(k % 4, ref_f(8'(6 * (k % 4 + 1)), 8'd4, 1'((k % 4) & 1)), 1'b0);
    end
    for (int i = 0; i < NREQ; i++) begin
      post(i, 8'(6 * (i + 1)), 8'd4, 1'(i & 1), (i < 2) ? 2 : 1);
    end
    wait_idle(300);
    chk("fair_start_pulses", start_cnt - s0, 6);

    // response backpressure
    rmask = '0;
    push(1, 8'd3, 1'b0);
    post(1, 8'd9, 8'd6, 1'b0, 1);
    wait_resp(50);
    push(3, 8'd4, 1'b0);
    post(3, 8'd20, 8'd8, 1'b0, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_no_ready", 32'(s_rdy), 0);
      chk("bp_resp_valid", 32'(s_rv), 32'h2);
      chk("bp_resp_result", 32'(s_res), 3);
    end
    rmask = '1;
    wait_idle(60);

    // timeout with stale Done held high
    mode = 2;
    f0 = flush_cnt;
    push(0, 8'd0, 1'b1);
    post(0, 8'd10, 8'd4, 1'b0, 1);
    wait_idle(60);
    chk("to_stale_latency", last_lat, 11);
    chk("to_stale_flush_before_resp", flush_at_resp - f0, 1);
    chk("to_stale_flush_total", flush_cnt - f0, 1);

    // timeout with Done never raised
    mode = 1;
    f0 = flush_cnt;
    push(2, 8'd0, 1'b1);
    post(2, 8'd7, 8'd3, 1'b1, 1);
    wait_idle(60);
    chk("to_low_latency", last_lat, 11);
    chk("to_low_flush_before_resp", flush_at_resp - f0, 1);

    // recovery after flush
    mode = 0;
    push(3, 8'd5, 1'b0);
    post(3, 8'd15, 8'd10, 1'b0, 1);
    wait_idle(50);
    chk("recover_latency", last_lat, 5);

    // reset while waiting
    mode = 1;
    push(1, 8'd0, 1'b1);
    post(1, 8'd5, 8'd5, 1'b0, 1);
    n = 0;
    while (pend[1] && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("mid_accept_budget", 0, 1);
    tick();
    tick();
    chk("mid_busy_before_reset", 32'(s_busy), 1);
    sb.delete();
    reset = 1'b1;
    tick();
    chk("mid_cop_reset", 32'(s_crst), 1);
    reset = 1'b0;
    tick();
    chk("mid_busy_after", 32'(s_busy), 0);
    chk("mid_resp_valid_after", 32'(s_rv), 0);
    mode = 0;
    push(0, 8'd3, 1'b0);
    push(2, 8'd15, 1'b0);
    post(0, 8'd9, 8'd12, 1'b0, 1);
    post(2, 8'd3, 8'd5, 1'b1, 1);
    wait_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
